// File: rtl/uart_rx_fifo.sv
// UART receiver with show-ahead receive FIFO.
// Mid-bit sampling off a 2-FF synchronised line; errors tagged or pulsed.
module uart_rx_fifo #(
    parameter int PULSES_BIT = 29,
    parameter int DATA_BITS  = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          data_Rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int W  = DATA_BITS + 1;
    localparam logic [15:0] HALF_LAST = 16'(PULSES_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(PULSES_BIT - 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic        ODD       = (PARITY_ODD != 0);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  perr_q, perr_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;

    logic [W-1:0]          mem_q [FIFO_DEPTH];
    logic [W-1:0]          mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_q, wr_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic [AW:0]           count_q, count_d;

    logic                  s_rx;
    logic                  tick;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  accept;
    logic [DATA_BITS-1:0]  shift_in;

    assign sync1_d = data_Rx;
    assign sync2_d = sync1_q;
    assign s_rx    = sync2_q;
    assign tick    = (cnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        if (MSB_FIRST != 0) shift_in = {shift_q[DATA_BITS-2:0], s_rx};
        else                shift_in = {s_rx, shift_q[DATA_BITS-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        push      = 1'b0;
        frame_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                perr_d = 1'b0;
                if (!s_rx) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = s_rx ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = shift_in;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == LAST_DATA)
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    perr_d  = (^shift_q) ^ s_rx ^ ODD;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (s_rx) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            BREAK: begin
                // Only a return to idle-high re-arms start detection.
                if (s_rx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign full     = (count_q == DEPTH_C);
    assign rx_valid = (count_q != '0);
    assign pop      = rx_valid & rx_ready;
    assign accept   = push & (!full | pop);
    assign overflow = push & full & !pop;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (accept) begin
            mem_d[wr_q] = {perr_q, shift_q};
            wr_d        = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign {rx_perr, rx_data} = mem_q[rd_q];
    assign fifo_count         = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: three parameter sets driven side by side.
// Stimulus queues expected words; a negedge monitor pops and compares.
module tb_uart_rx_fifo;

    localparam int PB    = 8;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic ln0 = 1'b1, ln1 = 1'b1, ln2 = 1'b1;
    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic pe0, pe1, pe2, v0, v1, v2;
    logic fe0, fe1, fe2, ov0, ov1, ov2;
    logic [2:0] fc0, fc1, fc2;
    logic r0, r1, r2;
    logic [2:0] frc = 3'b111;
    logic [2:0] rnd = 3'b000;
    logic rand_mode = 1'b0;

    assign r0 = rand_mode ? rnd[0] : frc[0];
    assign r1 = rand_mode ? rnd[1] : frc[1];
    assign r2 = rand_mode ? rnd[2] : frc[2];

    uart_rx_fifo #(.PULSES_BIT(PB), .DATA_BITS(8), .MSB_FIRST(1),
                   .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rst_n(rst_n), .data_Rx(ln0), .rx_data(d0), .rx_perr(pe0),
        .rx_valid(v0), .rx_ready(r0), .frame_err(fe0), .overflow(ov0),
        .fifo_count(fc0));

    uart_rx_fifo #(.PULSES_BIT(PB), .DATA_BITS(8), .MSB_FIRST(0),
                   .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .rst_n(rst_n), .data_Rx(ln1), .rx_data(d1), .rx_perr(pe1),
        .rx_valid(v1), .rx_ready(r1), .frame_err(fe1), .overflow(ov1),
        .fifo_count(fc1));

    uart_rx_fifo #(.PULSES_BIT(PB), .DATA_BITS(5), .MSB_FIRST(0),
                   .PARITY_EN(1), .PARITY_ODD(1), .FIFO_DEPTH(DEPTH)) u_c (
        .clk(clk), .rst_n(rst_n), .data_Rx(ln2), .rx_data(d2), .rx_perr(pe2),
        .rx_valid(v2), .rx_ready(r2), .frame_err(fe2), .overflow(ov2),
        .fifo_count(fc2));

    int n_chk = 0;
    int n_pass = 0;
    logic [9:0] q0[$], q1[$], q2[$];
    int fe_cnt[3] = '{0, 0, 0};
    int ov_cnt[3] = '{0, 0, 0};
    int fe_exp[3] = '{0, 0, 0};
    int ov_exp[3] = '{0, 0, 0};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic int qsize(int i);
        if (i == 0) return q0.size();
        if (i == 1) return q1.size();
        return q2.size();
    endfunction

    task automatic qpush(int i, logic [9:0] e);
        if (i == 0) q0.push_back(e);
        else if (i == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic pop_chk(int i, logic [9:0] act);
        logic [9:0] e;
        if (qsize(i) == 0) begin
            n_chk++;
            $display("FAIL spurious_word inst%0d: got %0h want none", i, act);
        end else begin
            if (i == 0) e = q0.pop_front();
            else if (i == 1) e = q1.pop_front();
            else e = q2.pop_front();
            chk($sformatf("word_inst%0d", i), 32'(act), 32'(e));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fe0) fe_cnt[0]++;
            if (fe1) fe_cnt[1]++;
            if (fe2) fe_cnt[2]++;
            if (ov0) ov_cnt[0]++;
            if (ov1) ov_cnt[1]++;
            if (ov2) ov_cnt[2]++;
            if (v0 && r0) pop_chk(0, {pe0, 1'b0, d0});
            if (v1 && r1) pop_chk(1, {pe1, 1'b0, d1});
            if (v2 && r2) pop_chk(2, {pe2, 4'b0, d2});
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        rnd = 3'($urandom_range(0, 7));
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic set_ln(int i, logic v);
        if (i == 0) ln0 = v;
        else if (i == 1) ln1 = v;
        else ln2 = v;
    endtask

    task automatic wait_bit();
        repeat (PB) @(posedge clk);
        #1;
    endtask

    // Serialise one frame; expected word or error is booked at the stop bit.
    task automatic send(int i, logic [8:0] w_in, bit bad_par, bit stop,
                        bit pop_at_push);
        int db;
        bit msb, pen, odd;
        logic [8:0] w;
        logic p, perr;
        int ones;
        if (i == 0) begin db = 8; msb = 1; pen = 0; odd = 0; end
        else if (i == 1) begin db = 8; msb = 0; pen = 1; odd = 0; end
        else begin db = 5; msb = 0; pen = 1; odd = 1; end
        w    = w_in & 9'((1 << db) - 1);
        ones = $countones(w);
        p    = logic'(ones % 2) ^ odd ^ bad_par;
        perr = pen && (((ones + int'(p)) % 2) != int'(odd));
        set_ln(i, 1'b0);
        wait_bit();
        for (int k = 0; k < db; k++) begin
            set_ln(i, msb ? w[db-1-k] : w[k]);
            wait_bit();
        end
        if (pen) begin
            set_ln(i, p);
            wait_bit();
        end
        set_ln(i, stop);
        if (!stop) fe_exp[i]++;
        else if (qsize(i) >= DEPTH && !pop_at_push) ov_exp[i]++;
        else qpush(i, {perr, w});
        if (pop_at_push) begin
            repeat (6) @(posedge clk);
            #1 frc[i] = 1'b1;
            @(posedge clk);
            #1 frc[i] = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            wait_bit();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_a", 32'(v0), 0);
        chk("rst_data_a", 32'(d0), 0);
        chk("rst_perr_a", 32'(pe0), 0);
        chk("rst_count_a", 32'(fc0), 0);
        chk("rst_ferr_a", 32'(fe0), 0);
        chk("rst_ovf_a", 32'(ov0), 0);
        chk("rst_valid_b", 32'(v1), 0);
        chk("rst_valid_c", 32'(v2), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(0, 9'hA5, 0, 1, 0);
        send(1, 9'hA5, 0, 1, 0);
        send(2, 9'h13, 0, 1, 0);
        send(1, 9'h07, 0, 1, 0);
        send(1, 9'h07, 1, 1, 0);
        send(2, 9'h07, 0, 1, 0);
        send(2, 9'h07, 1, 1, 0);
        wait_bit();

        send(0, 9'h3C, 0, 0, 0);
        repeat (40 * PB) @(posedge clk);
        #1;
        chk("ferr_count", 32'(fc0), 0);
        chk("ferr_pulses", 32'(fe_cnt[0]), 32'(fe_exp[0]));
        set_ln(0, 1'b1);
        wait_bit();
        wait_bit();
        send(0, 9'h55, 0, 1, 0);
        wait_bit();

        frc[0] = 1'b0;
        for (int n = 0; n < 4; n++) send(0, 9'($urandom), 0, 1, 0);
        wait_bit();
        chk("full_count", 32'(fc0), 32'(qsize(0)));
        send(0, 9'($urandom), 0, 1, 0);
        wait_bit();
        chk("ovf_count", 32'(fc0), 32'(qsize(0)));
        chk("ovf_pulses", 32'(ov_cnt[0]), 32'(ov_exp[0]));
        send(0, 9'($urandom), 0, 1, 1);
        wait_bit();
        chk("pushpop_count", 32'(fc0), 32'(qsize(0)));
        chk("pushpop_ovf", 32'(ov_cnt[0]), 32'(ov_exp[0]));
        frc[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_count", 32'(fc0), 0);

        set_ln(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        set_ln(0, 1'b1);
        repeat (4 * PB) @(posedge clk);
        #1;
        chk("glitch_valid", 32'(v0), 0);
        chk("glitch_count", 32'(fc0), 0);

        frc[0] = 1'b0;
        send(0, 9'h11, 0, 1, 0);
        set_ln(0, 1'b0);
        wait_bit();
        set_ln(0, 1'b1);
        wait_bit();
        set_ln(0, 1'b0);
        wait_bit();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(v0), 0);
        chk("mid_rst_count", 32'(fc0), 0);
        chk("mid_rst_data", 32'(d0), 0);
        chk("mid_rst_ferr", 32'(fe0), 0);
        q0.delete();
        set_ln(0, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        frc[0] = 1'b1;
        wait_bit();
        wait_bit();
        send(0, 9'h6B, 0, 1, 0);
        wait_bit();

        rand_mode = 1'b1;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 3; i++) begin
                send(i, 9'($urandom), 1'($urandom_range(0, 1)), 1, 0);
                wait_bit();
            end
        end
        rand_mode = 1'b0;
        frc = 3'b111;
        repeat (50) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("left_words%0d", i), 32'(qsize(i)), 0);
            chk($sformatf("ferr_total%0d", i), 32'(fe_cnt[i]), 32'(fe_exp[i]));
            chk($sformatf("ovf_total%0d", i), 32'(ov_cnt[i]), 32'(ov_exp[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
